// File: rtl/seqdet_pkg.sv
// Shared definitions for the parametrised symbol-sequence detector: mode
// encodings, the default 1,2,3 pattern and the progress-width helper.
package seqdet_pkg;

  localparam bit MODE_PULSE  = 1'b0;
  localparam bit MODE_STICKY = 1'b1;

  localparam int         DEFAULT_SYM_W   = 2;
  localparam int         DEFAULT_PAT_LEN = 3;
  localparam logic [5:0] DEFAULT_PATTERN = 6'b11_10_01;

  // Bits needed to hold values 0..v-1 (v >= 2 in every use here).
  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= v) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/seqdet_next.sv
// Combinational next-progress function: the longest pattern prefix that is a
// suffix of (matched history, s). Optionally excludes the full-length match.
module seqdet_next
  import seqdet_pkg::*;
#(
  parameter int                         SYM_W      = DEFAULT_SYM_W,
  parameter int                         PAT_LEN    = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN*SYM_W-1:0]   PATTERN    = DEFAULT_PATTERN,
  parameter bit                         ALLOW_FULL = 1'b1,
  localparam int                        PW         = clog2(PAT_LEN + 1)
) (
  input  logic [PW-1:0]    prog,
  input  logic [SYM_W-1:0] s,
  output logic [PW-1:0]    next_prog,
  output logic             full
);

  logic [PAT_LEN:1] cand;

  // hist_ok[p] is an elaboration-time constant: PATTERN[0..k-2] equals the
  // tail PATTERN[p-k+1..p-1] of a history of length p.
  for (genvar gk = 1; gk <= PAT_LEN; gk++) begin : g_k
    logic [PAT_LEN:0] hist_ok;
    for (genvar gp = 0; gp <= PAT_LEN; gp++) begin : g_p
      if (gp == PAT_LEN || gk > gp + 1) begin : g_none
        assign hist_ok[gp] = 1'b0;
      end else if (gk == 1) begin : g_empty
        assign hist_ok[gp] = 1'b1;
      end else begin : g_cmp
        assign hist_ok[gp] =
          (PATTERN[(gk-1)*SYM_W-1:0] == PATTERN[gp*SYM_W-1 -: (gk-1)*SYM_W]);
      end
    end
    assign cand[gk] = hist_ok[prog] && (s == PATTERN[gk*SYM_W-1 -: SYM_W]);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_prog = '0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (cand[k] && (k < PAT_LEN || ALLOW_FULL)) next_prog = PW'(k);
    end
  end

  assign full = cand[PAT_LEN];

endmodule

// File: rtl/seq_detector.sv
// Parametrised symbol-sequence detector with sticky or pulse match modes.
// Optional saturating match counter enabled by SEQDET_COUNT_EN.
module seq_detector
  import seqdet_pkg::*;
#(
  parameter int                       SYM_W   = DEFAULT_SYM_W,
  parameter int                       PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN*SYM_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter bit                       STICKY  = MODE_STICKY,
  parameter int                       CNT_W   = 8,
  localparam int                      PW      = clog2(PAT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             clear,
  output logic             hit,
  output logic [PW-1:0]    progress
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  if (SYM_W < 1 || PAT_LEN < 1 || CNT_W < 1) begin : g_bad_params
    $error("seq_detector: SYM_W, PAT_LEN and CNT_W must all be >= 1");
  end

  logic [PW-1:0] prog, prog_d, next_prog;
  logic          hit_d, full, take;

  seqdet_next #(
    .SYM_W      (SYM_W),
    .PAT_LEN    (PAT_LEN),
    .PATTERN    (PATTERN),
    .ALLOW_FULL (STICKY == MODE_STICKY)
  ) u_next (
    .prog      (prog),
    .s         (in_sym),
    .next_prog (next_prog),
    .full      (full)
  );

  // A sticky detector that has already hit ignores every further symbol.
  assign take = in_valid && !(STICKY == MODE_STICKY && hit);

  always_comb begin
    prog_d = prog;
    hit_d  = hit;
    if (clear) begin
      prog_d = '0;
      hit_d  = 1'b0;
    end else if (take) begin
      prog_d = next_prog;
      hit_d  = full;
    end else if (STICKY == MODE_PULSE) begin
      hit_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog <= '0;
      hit  <= 1'b0;
    end else begin
      prog <= prog_d;
      hit  <= hit_d;
    end
  end

  assign progress = prog;

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt <= '0;
    end else if (!clear && take && full && match_cnt != {CNT_W{1'b1}}) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule
